// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one cordic core between NUM_REQ requesters.
// Accepts one angle at a time, pulses core_start, waits for the core's
// done low->high handshake, then returns x/y to the granted requester.
// Optional build macro: CORDIC_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, no round-robin pointer). Default is round-robin.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for core_ready and any request; grant here
// ISSUE     | core_start pulse, core_angle already holds angle_q
// WAIT_LOW  | waiting for the core to drop done
// WAIT_DONE | waiting for done to rise; capture x/y on that cycle
// RESP      | resp_valid to the granted requester until it accepts
module cordic_arbiter #(
    parameter int BIT_WIDTH = 30,
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [BIT_WIDTH-1:0]         resp_x,
    output logic [BIT_WIDTH-1:0]         resp_y,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         busy,
    output logic                         core_start,
    output logic [BIT_WIDTH-1:0]         core_angle,
    input  logic                         core_ready,
    input  logic                         core_done,
    input  logic [BIT_WIDTH-1:0]         core_x,
    input  logic [BIT_WIDTH-1:0]         core_y
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic [BIT_WIDTH-1:0]   angle_q, angle_d;
    logic [BIT_WIDTH-1:0]   resp_x_q, resp_x_d;
    logic [BIT_WIDTH-1:0]   resp_y_q, resp_y_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic                   core_start_q, core_start_d;
    logic                   busy_q, busy_d;

    logic [IDX_W-1:0]       search_base;
    logic [IDX_W-1:0]       winner;
    logic                   found;
    logic [NUM_REQ-1:0]     rotated;
    logic [2*NUM_REQ-1:0]   doubled;
    logic [BIT_WIDTH-1:0]   angle_sel;
    logic                   grant_fire;
    logic                   resp_fire;

    // Find the first valid requester at or after search_base, cyclically.
    always_comb begin : p_arb
        int wsum;
        wsum    = 0;
        doubled = {req_valid, req_valid};
        rotated = NUM_REQ'(doubled >> search_base);
        found   = 1'b0;
        winner  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                wsum  = int'(search_base) + k;
                if (wsum >= NUM_REQ) begin
                    wsum = wsum - NUM_REQ;
                end
                winner = IDX_W'(wsum);
            end
        end
    end

    // Select the winner's angle from the flattened request bus.
    always_comb begin
        angle_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDX_W'(k)) begin
                angle_sel = req_angle[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Gated by reset so no acceptance is signalled while the block is held in reset.
    assign grant_fire = (state_q == S_IDLE) && core_ready && found && !reset;
    assign resp_fire  = (state_q == S_RESP) && (|(resp_ready & resp_valid_q));
    assign req_ready  = grant_fire ? (NUM_REQ'(1) << winner) : '0;

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer moves to one past the winner on every grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_fire) begin
            rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign search_base = rr_ptr_q;
`endif

    // Next-state and next-output computation; outputs are registered from state_d.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        angle_d    = angle_q;
        resp_x_d   = resp_x_q;
        resp_y_d   = resp_y_q;
        case (state_q)
            S_IDLE: begin
                if (grant_fire) begin
                    state_d    = S_ISSUE;
                    angle_d    = angle_sel;
                    grant_id_d = winner;
                end
            end
            S_ISSUE:    state_d = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!core_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    resp_x_d = core_x;
                    resp_y_d = core_y;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
        core_start_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_RESP) ? (NUM_REQ'(1) << grant_id_d) : '0;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            angle_q      <= '0;
            resp_x_q     <= '0;
            resp_y_q     <= '0;
            resp_valid_q <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            angle_q      <= angle_d;
            resp_x_q     <= resp_x_d;
            resp_y_q     <= resp_y_d;
            resp_valid_q <= resp_valid_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_x     = resp_x_q;
    assign resp_y     = resp_y_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign core_angle = angle_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase against a transaction-level model.
module tb_cordic_arbiter;
    localparam int BW = 30;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*BW-1:0]  req_angle;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [BW-1:0]     resp_x, resp_y;
    logic [IW-1:0]     grant_id;
    logic              busy, core_start, core_ready, core_done;
    logic [BW-1:0]     core_angle, core_x, core_y;
    logic [BW-1:0]     ang [NR];

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    cordic_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_x(resp_x), .resp_y(resp_y), .grant_id(grant_id), .busy(busy),
        .core_start(core_start), .core_angle(core_angle),
        .core_ready(core_ready), .core_done(core_done),
        .core_x(core_x), .core_y(core_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always_comb begin
        req_angle = '0;
        for (int i = 0; i < NR; i++) req_angle[i*BW +: BW] = ang[i];
    end

    function automatic logic [BW-1:0] fx(input logic [BW-1:0] a);
        return a ^ 30'h2AAA_AAAA;
    endfunction
    function automatic logic [BW-1:0] fy(input logic [BW-1:0] a);
        return a + 30'h0123_4567;
    endfunction
    function automatic logic [NR-1:0] oh(input int i);
        return NR'(1) << i;
    endfunction

    // Core model: done drops the cycle after start, rises lat cycles later.
    logic       core_done_m = 1'b1;
    int         cnt_m = 0;
    int         lat = 1;
    logic       cr_en = 1'b1;
    logic [BW-1:0] cx_m = '0, cy_m = '0;
    always @(posedge clk) begin
        if (reset) begin
            core_done_m <= 1'b1; cnt_m <= 0; cx_m <= '0; cy_m <= '0;
        end else if (core_start) begin
            core_done_m <= 1'b0; cnt_m <= lat;
            cx_m <= fx(core_angle); cy_m <= fy(core_angle);
        end else if (cnt_m != 0) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1) core_done_m <= 1'b1;
        end
    end
    assign core_ready = core_done_m & cr_en;
    assign core_done  = core_done_m;
    assign core_x     = cx_m;
    assign core_y     = cy_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask

    // Called in a drive phase; returns at the sample point of the first resp_valid cycle.
    task automatic wait_resp(input int budget, output int n);
        n = 0;
        smp();
        while (resp_valid == '0 && n < budget) begin
            step(); smp(); n++;
        end
        if (resp_valid == '0) begin
            checks++; failures++;
            $display("FAIL resp_timeout: got no resp_valid within %0d cycles", budget);
        end
    endtask

    // Reference arbitration: first pending index at or after the start point.
    function automatic int model_pick(input bit pend [NR], input int ptr);
        int start;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = ptr;
`endif
        for (int k = 0; k < NR; k++) begin
            if (pend[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},  req_ready,  0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_grant_id"},   grant_id,   0);
        chk({tag, "_core_angle"}, core_angle, 0);
        chk({tag, "_resp_x"},     resp_x,     0);
        chk({tag, "_resp_y"},     resp_y,     0);
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic [BW-1:0] angle;
        int            lat;
        int            exp_rr;
        int            exp_fp;
    } vec_t;

    vec_t tab [6];

    initial begin
        int n, w, last, seen;
        int exp_seq [6];
        logic [NR-1:0] fmask;
        logic [BW-1:0] hold_x;
        bit  pend [NR];
        bit  m_busy;
        int  m_owner, m_ptr, pick, done_cnt, wait_cnt;
        logic [BW-1:0] m_angle;
        logic [NR-1:0] exp_rdy;

        tab[0] = '{4'b0001, 30'h2000_0000, 30, 0, 0};
        tab[1] = '{4'b1111, 30'h0123_4560,  3, 1, 0};
        tab[2] = '{4'b1001, 30'h3FFF_FFF0,  5, 3, 0};
        tab[3] = '{4'b0110, 30'h1555_5550,  1, 1, 1};
        tab[4] = '{4'b0010, 30'h0000_0010,  2, 1, 1};
        tab[5] = '{4'b1000, 30'h2AAA_AAA0,  4, 3, 3};

        // Reset with all requesters valid: nothing may be accepted.
        reset = 1'b1; req_valid = '1; resp_ready = '0; cr_en = 1'b1; lat = 1;
        for (int i = 0; i < NR; i++) ang[i] = BW'(32'h0ABC_0000 + i);
        step(); step(); smp();
        check_reset_vals("reset");
        step(); reset = 1'b0; req_valid = '0;

        // Directed vector table: one full transaction per entry.
        for (int e = 0; e < 6; e++) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
            w = tab[e].exp_fp;
`else
            w = tab[e].exp_rr;
`endif
            lat = tab[e].lat; req_valid = tab[e].mask; resp_ready = '1;
            for (int i = 0; i < NR; i++) ang[i] = tab[e].angle + BW'(i);
            smp();
            chk("vec_req_ready", req_ready, oh(w));
            step(); req_valid = '0; smp();
            chk("vec_core_start_c1", core_start, 1);
            chk("vec_grant_id", grant_id, w);
            chk("vec_core_angle", core_angle, tab[e].angle + BW'(w));
            chk("vec_busy", busy, 1);
            step(); smp();
            chk("vec_core_start_c2", core_start, 0);
            step(); wait_resp(100, n);
            chk("vec_resp_latency", 3 + n, 3 + tab[e].lat);
            chk("vec_resp_valid", resp_valid, oh(w));
            chk("vec_resp_x", resp_x, fx(tab[e].angle + BW'(w)));
            chk("vec_resp_y", resp_y, fy(tab[e].angle + BW'(w)));
            step();
        end

        // Response stall on requester 2 with requester 0 waiting.
        lat = 3; req_valid = 4'b0100; resp_ready = '0;
        smp(); chk("stall_grant", req_ready, 4'b0100);
        step(); req_valid = '0;
        wait_resp(100, n);
        chk("stall_resp_valid0", resp_valid, 4'b0100);
        hold_x = fx(ang[2]);
        for (int s = 0; s < 10; s++) begin
            step(); req_valid = 4'b0001; resp_ready = 4'b1011; smp();
            chk("stall_resp_valid", resp_valid, 4'b0100);
            chk("stall_resp_x", resp_x, hold_x);
            chk("stall_busy", busy, 1);
            chk("stall_no_grant", req_ready, 0);
        end
        step(); resp_ready = '1; smp();
        chk("stall_handshake", resp_valid, 4'b0100);
        step(); smp();
        chk("stall_next_grant", req_ready, 4'b0001);
        step(); req_valid = '0;
        wait_resp(100, n);
        chk("stall_next_resp", resp_valid, 4'b0001);
        step();

        // Core not ready: no grant until core_ready rises.
        cr_en = 1'b0; req_valid = 4'b0010;
        for (int s = 0; s < 4; s++) begin
            smp();
            chk("nrdy_req_ready", req_ready, 0);
            chk("nrdy_core_start", core_start, 0);
            chk("nrdy_busy", busy, 0);
            step();
        end
        cr_en = 1'b1; smp();
        chk("nrdy_grant", req_ready, 4'b0010);
        step(); req_valid = '0;
        wait_resp(100, n);
        chk("nrdy_resp", resp_valid, 4'b0010);
        step();

        // Reset while waiting for done.
        lat = 20; req_valid = 4'b1000;
        smp(); chk("rst_mid_grant", req_ready, 4'b1000);
        step(); req_valid = '0;
        for (int s = 0; s < 5; s++) begin smp(); step(); end
        reset = 1'b1; smp(); step(); reset = 1'b0; smp();
        check_reset_vals("rst_mid");
        seen = 0;
        for (int s = 0; s < 40; s++) begin
            step(); smp();
            if (resp_valid != '0) seen++;
        end
        chk("rst_mid_no_resp", seen, 0);
        step();

        // Continuous requests: round-robin order, or fixed priority with 0 and 3.
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        fmask = 4'b1001;
        exp_seq = '{0, 0, 0, 0, 0, 0};
`else
        fmask = 4'b1111;
        exp_seq = '{0, 1, 2, 3, 0, 1};
`endif
        lat = 2; resp_ready = '1; req_valid = fmask; last = 0;
        for (int g = 0; g < 6; g++) begin
            n = 0; smp();
            while (req_ready == '0 && n < 60) begin step(); smp(); n++; end
            chk("fair_grant", req_ready, oh(exp_seq[g]));
            if (g > 0) chk("fair_spacing", cyc_cnt - last, 4 + lat);
            last = cyc_cnt;
            step(); smp();
            chk("fair_grant_id", grant_id, exp_seq[g]);
            step();
        end
        req_valid = '0;
        wait_resp(100, n);
        step();

        // Randomized phase against the transaction-level model.
        reset = 1'b1; resp_ready = '0; step(); step(); reset = 1'b0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_angle = '0;
        done_cnt = 0; wait_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ang[i]  = BW'($urandom);
                end
                req_valid[i] = pend[i];
            end
            resp_ready = NR'($urandom);
            cr_en = ($urandom_range(0, 7) != 0);
            lat = $urandom_range(1, 6);
            smp();
            exp_rdy = '0; pick = -1;
            if (!m_busy && core_ready && (req_valid != '0)) begin
                pick = model_pick(pend, m_ptr);
                exp_rdy = oh(pick);
            end
            chk("rand_req_ready", req_ready, exp_rdy);
            if (resp_valid != '0) begin
                chk("rand_resp_valid", resp_valid, m_busy ? oh(m_owner) : NR'(0));
                chk("rand_resp_x", resp_x, fx(m_angle));
                chk("rand_resp_y", resp_y, fy(m_angle));
                if (m_busy && resp_ready[m_owner]) begin
                    m_busy = 1'b0; done_cnt++;
                end
            end else if (m_busy) begin
                wait_cnt++;
                if (wait_cnt == 100) chk("rand_resp_timeout", wait_cnt, 0);
            end
            if (pick >= 0) begin
                m_busy = 1'b1; m_owner = pick; m_angle = ang[pick];
                pend[pick] = 1'b0; m_ptr = (pick + 1) % NR; wait_cnt = 0;
            end
            step();
        end
        chk("rand_completions_ge20", done_cnt >= 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin arbiter and sequencer that shares one `cordic` core between `NUM_REQ` independent requesters. It accepts one angle at a time over a valid/ready handshake and issues it to the core with a one-cycle start pulse. It tracks the core's done handshake, then returns the captured x/y result to the granted requester over a per-requester response handshake. It sits between the trig consumers and the single `cordic` instance; the parent wires the core's ports to the `core_*` ports below.

## Interface
- `BIT_WIDTH`, 30, angle and result width; must match the attached `cordic`.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `IDX_W`, 2, requester index width; must be ≥ clog2(`NUM_REQ`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_angle` in `NUM_REQ*BIT_WIDTH`: flattened angles; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- `req_ready` out `NUM_REQ`: one-hot acceptance strobe.
- `resp_valid` out `NUM_REQ`: one-hot result-valid flag.
- `resp_ready` in `NUM_REQ`: per-requester result acceptance.
- `resp_x`, `resp_y` out `BIT_WIDTH`: shared result bus, meaningful only while a `resp_valid` bit is 1.
- `grant_id` out `IDX_W`: index of the current or last granted requester.
- `busy` out 1: 1 in any state other than IDLE.
- `core_start` out 1; `core_angle` out `BIT_WIDTH`: drive the core.
- `core_ready`, `core_done` in 1; `core_x`, `core_y` in `BIT_WIDTH`: from the core.

## Operation
- **States:** IDLE, ISSUE, WAIT_LOW, WAIT_DONE, RESP.
- **IDLE → ISSUE:**
  - Taken when `core_ready`=1 and any `req_valid` bit is 1.
  - The winner is chosen round-robin, starting the search at `rr_ptr`.
  - `req_ready[winner]`=1 combinationally in that cycle; this cycle is the handshake.
  - The winner's angle is latched into `angle_q`, `grant_id` is set to the winner, and `rr_ptr` is set to winner+1, wrapping from `NUM_REQ`-1 to 0.
- **ISSUE:** `core_start`=1 for exactly this one cycle, then → WAIT_LOW.
- **WAIT_LOW:** stays until `core_done`=0, then → WAIT_DONE.
- **WAIT_DONE:** stays until `core_done`=1. On that cycle `core_x`/`core_y` are captured into `resp_x`/`resp_y`, then → RESP.
- **RESP:**
  - `resp_valid[grant_id]`=1 until `resp_ready[grant_id]`=1; then → IDLE.
  - `resp_ready` bits of other requesters are ignored.
- **Core drive:** `core_angle` = `angle_q` at all times, so it is stable from ISSUE through capture.
- **Requester rules:**
  - Once asserted, a requester holds `req_valid` and its angle until it sees `req_ready`.
  - Requests arriving while busy simply wait; none are dropped.
  - A requester in RESP may hold `req_valid` for its next request. That request competes in the next IDLE cycle with the normal round-robin pointer.
- **Single outstanding:** only one computation is in flight at a time, so there is no queue.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `grant_id`=0, `angle_q`=0, `resp_x`=`resp_y`=0, `resp_valid`=0, `req_ready`=0, `core_start`=0, `busy`=0.
- **Reset mid-operation:** any in-flight result is discarded and nothing is returned. The core shares the same `reset`.
- **Latency:** request accepted at cycle 0, `core_start` at cycle 1. If the core drops done at cycle 2 and raises it at cycle 2+L, `resp_valid` is high from cycle 3+L.
- **Response handshake:** `resp_valid` is held across `resp_ready`=0 stalls. IDLE is re-entered the cycle after the handshake, so back-to-back grants are spaced ≥5 cycles apart.
- **`core_ready`=0 in IDLE:** no grant is made and `req_ready` stays 0.
- **Single requester:** `rr_ptr` wrap still occurs, and that requester is granted on every IDLE pass.

## Configuration
- **`CORDIC_ARB_FIXED_PRIO_EN`** defined: fixed priority, lowest index wins. `rr_ptr` is not implemented and every search starts at 0.
- **Undefined (default):** round-robin arbitration as described above.

## Test plan
- **Single request:** reset, then req 0 with angle 0x20000000 and a core model with L=30. Expect `req_ready[0]` at cycle 0, a one-cycle `core_start` at cycle 1, and `resp_valid[0]` at cycle 33 with `resp_x`/`resp_y` equal to the model's outputs.
- **Round-robin fairness:** all four requesters hold valid continuously with `resp_ready`=1. Expect grants in order 0,1,2,3,0,1 and `grant_id` matching each grant.
- **Response stall:** hold `resp_ready[2]`=0 for 10 cycles in RESP. Expect `resp_valid[2]` and the result held stable, no new grant, and `busy`=1. The next grant occurs 1 cycle after `resp_ready[2]` rises.
- **Core not ready:** `core_ready`=0 with req 1 valid. Expect `req_ready`=0 and `core_start`=0. When `core_ready` rises, expect a grant on that cycle.
- **Reset mid-operation:** assert `reset` in WAIT_DONE. Expect every output at its reset value the next cycle and no `resp_valid` afterwards.
- **With `CORDIC_ARB_FIXED_PRIO_EN`:** requesters 0 and 3 continuously valid. Expect requester 0 granted every time and requester 3 never granted.
